// File: rtl/seq_normalizer_pkg.sv
// Shared definitions for the iterative left-normalizer and its companion shifter.
//   state_t  : controller states (IDLE, SHIFT, DONE), 2-bit encoding
//   width_ok : returns 1 when a shift_bits-wide count can hold every shift
//              amount for an N-bit operand (2^shift_bits >= N)
package seq_normalizer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic bit width_ok(input int unsigned n, input int unsigned sb);
    longint unsigned span;
    span = longint'(1) << sb;
    return span >= longint'(n);
  endfunction

endpackage

// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: strips leading zeros from an N-bit operand, one
// bit per clock. The shifted-out count and the normalized value together
// reproduce the operand through a right shift.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   start       : request, sampled only in IDLE
//   in          : operand, latched on the accepted start edge
//   busy        : high in SHIFT and DONE
//   done        : one-cycle pulse, results valid
//   out         : normalized operand (MSB = 1 unless zero = 1)
//   shift_count : leading zeros removed
//   zero        : operand was all zeros
module seq_normalizer
  import seq_normalizer_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned shift_bits = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          in,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          out,
  output logic [shift_bits-1:0] shift_count,
  output logic                  zero
);

  if (!width_ok(N, shift_bits)) begin : g_width_check
    $error("seq_normalizer: shift_bits too narrow for N");
  end

  state_t                state;
  logic [N-1:0]          work;
  logic [shift_bits-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      zero        <= 1'b0;
      out         <= '0;
      shift_count <= '0;
      work        <= '0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            work  <= in;
            count <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (work == '0) begin
            zero        <= 1'b1;
            out         <= '0;
            shift_count <= '0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else if (work[N-1]) begin
            zero        <= 1'b0;
            out         <= work;
            shift_count <= count;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            // A nonzero operand reaches its MSB after at most N-1 shifts,
            // so count never wraps.
            work  <= {work[N-2:0], 1'b0};
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_normalizer.sv
module tb_seq_normalizer;

  localparam int unsigned N  = 32;
  localparam int unsigned SB = 5;
  localparam int MAX_WAIT    = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  in;
  logic          busy;
  logic          done;
  logic [N-1:0]  out;
  logic [SB-1:0] shift_count;
  logic          zero;

  int checks   = 0;
  int failures = 0;

  seq_normalizer #(.N(N), .shift_bits(SB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in          (in),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .shift_count (shift_count),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] opnd;
    logic [N-1:0] exp_out;
    int           exp_sc;
    bit           exp_zero;
    int           exp_lat;
  } vec_t;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: count leading zeros from the MSB down, normalize by plain
  // multiplication, latency is one cycle per shift plus the terminating check.
  task automatic model(input logic [N-1:0] v, output logic [N-1:0] o,
                       output int sc, output bit z, output int lat);
    int lz;
    lz = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) break;
      lz++;
    end
    if (v == 0) begin
      z = 1'b1; o = '0; sc = 0; lat = 1;
    end else begin
      z = 1'b0; sc = lz; lat = lz + 1;
      o = N'(longint'(v) * (longint'(1) << lz));
    end
  endtask

  // Applies one start pulse and waits (bounded) for done. Returns the number
  // of edges after the accepting edge until done was seen.
  task automatic run_op(input logic [N-1:0] v, output int lat, output bit timed_out);
    start = 1'b1;
    in    = v;
    @(posedge clk); #1;
    start = 1'b0;
    in    = $urandom;
    lat = 0;
    timed_out = 1'b1;
    for (int c = 0; c < MAX_WAIT; c++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    logic [N-1:0] m_out;
    int  m_sc, m_lat, lat, dones;
    bit  m_z, to;
    logic [N-1:0] v;

    vecs.push_back('{32'h8000_0000, 32'h8000_0000,  0, 1'b0,  1});
    vecs.push_back('{32'h0000_0001, 32'h8000_0000, 31, 1'b0, 32});
    vecs.push_back('{32'h0012_3456, 32'h91A2_B000, 11, 1'b0, 12});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000,  0, 1'b1,  1});
    vecs.push_back('{32'h7FFF_FFFF, 32'hFFFF_FFFE,  1, 1'b0,  2});
    vecs.push_back('{32'h0000_8001, 32'h8001_0000, 16, 1'b0, 17});

    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out", out, 0);
    chk("reset_sc", shift_count, 0);
    chk("reset_zero", zero, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].opnd, lat, to);
      chk("vec_timeout", to, 0);
      chk("vec_out", out, vecs[i].exp_out);
      chk("vec_sc", shift_count, vecs[i].exp_sc);
      chk("vec_zero", zero, vecs[i].exp_zero);
      chk("vec_lat", lat, vecs[i].exp_lat);
      chk("vec_busy_done", busy, 1);
      chk("vec_roundtrip", vecs[i].exp_zero ? 0 : (out >> shift_count), vecs[i].opnd);
      @(posedge clk); #1;
      chk("vec_done_pulse", done, 0);
      chk("vec_busy_idle", busy, 0);
      chk("vec_hold_out", out, vecs[i].exp_out);
    end

    // start held high with in changing while the operation runs
    start = 1'b1;
    in    = 32'h0000_0F00;
    @(posedge clk); #1;
    dones = 0;
    to = 1'b1;
    for (int c = 0; c < MAX_WAIT; c++) begin
      in = $urandom | 32'h8000_0000;
      @(posedge clk); #1;
      chk("hold_busy", busy, 1);
      if (done) begin
        dones++;
        to = 1'b0;
        start = 1'b0;
        break;
      end
    end
    chk("hold_timeout", to, 0);
    chk("hold_out", out, 32'hF000_0000);
    chk("hold_sc", shift_count, 20);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
      chk("hold_idle_busy", busy, 0);
    end
    chk("hold_single_done", dones, 1);

    // reset mid-SHIFT abandons the operation
    start = 1'b1;
    in    = 32'h0000_00FF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_out", out, 0);
    chk("midrst_sc", shift_count, 0);
    chk("midrst_zero", zero, 0);
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_op(32'h4000_0000, lat, to);
    chk("postrst_timeout", to, 0);
    chk("postrst_out", out, 32'h8000_0000);
    chk("postrst_sc", shift_count, 1);
    chk("postrst_lat", lat, 2);
    @(posedge clk); #1;

    // random sweep
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 49) == 0) v = '0;
      else v = $urandom >> $urandom_range(0, 31);
      model(v, m_out, m_sc, m_z, m_lat);
      run_op(v, lat, to);
      chk("rnd_timeout", to, 0);
      chk("rnd_out", out, m_out);
      chk("rnd_sc", shift_count, m_sc);
      chk("rnd_zero", zero, m_z);
      chk("rnd_lat", lat, m_lat);
      if (!m_z) chk("rnd_roundtrip", out >> shift_count, v);
      chk("rnd_lat_rule", lat, shift_count + 1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
